// File: rtl/msk_rnd_supplier.sv
// Fresh-randomness supplier for masked gadgets: a 64-bit LFSR stepped RW times per advance.
// It takes a two-word seed, warms up for WARM+1 advances, then serves one word per handshake.
module msk_rnd_supplier #(
  parameter int d    = 2,
  parameter int RW   = d*(d-1),
  parameter int WARM = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   seed_in,
  input  logic          seed_valid,
  output logic [RW-1:0] rnd_out,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic          seeded
);

  typedef enum logic [1:0] {IDLE, SEED_HI, WARMUP, RUN} state_t;

  localparam logic [7:0] WARM_C = 8'(WARM);

  state_t        state_q, state_d;
  logic [63:0]   s_q, s_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic          vld_q, vld_d;

  logic [63:0]   adv_s;
  logic [RW-1:0] adv_w;
  logic [63:0]   seed_full;

  // RW chained LFSR steps; bit i of the word is the feedback of step i.
  always_comb begin
    adv_s = s_q;
    adv_w = '0;
    for (int i = 0; i < RW; i++) begin
      adv_w[i] = adv_s[63] ^ adv_s[62] ^ adv_s[60] ^ adv_s[59];
      adv_s    = {adv_s[62:0], adv_w[i]};
    end
  end

  assign seed_full = {seed_in, s_q[31:0]};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    vld_d   = vld_q;
    case (state_q)
      SEED_HI: begin
        if (seed_valid) begin
          // An all-zero state would lock the LFSR, so substitute 1.
          s_d     = (seed_full == 64'd0) ? 64'd1 : seed_full;
          cnt_d   = 8'd0;
          state_d = WARMUP;
        end
      end
      default: begin
        if (seed_valid) begin
          s_d     = {s_q[63:32], seed_in};
          vld_d   = 1'b0;
          state_d = SEED_HI;
        end else if (state_q == WARMUP) begin
          s_d = adv_s;
          if (cnt_q == WARM_C) begin
            rnd_d   = adv_w;
            vld_d   = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (state_q == RUN && rnd_ready) begin
          s_d   = adv_s;
          rnd_d = adv_w;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 64'd0;
      cnt_q   <= 8'd0;
      rnd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      vld_q   <= vld_d;
    end
  end

  assign rnd_out   = rnd_q;
  assign rnd_valid = vld_q;
  assign seeded    = (state_q == RUN);

endmodule

// File: tb/tb_msk_rnd_supplier.sv
// Directed-plus-random bench for msk_rnd_supplier against a bit-stream recurrence model.
module tb_msk_rnd_supplier;
  localparam int D    = 2;
  localparam int RW   = D*(D-1);
  localparam int WARM = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   seed_in;
  logic          seed_valid;
  logic [RW-1:0] rnd_out;
  logic          rnd_valid;
  logic          rnd_ready;
  logic          seeded;

  always #5 clk = ~clk;

  msk_rnd_supplier #(.d(D), .RW(RW), .WARM(WARM)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .seeded     (seeded)
  );

  int checks = 0;
  int errors = 0;

  // Output bit stream x[n] = x[n-64]^x[n-63]^x[n-61]^x[n-60]; hist holds the last 64 bits, oldest first.
  bit hist[$];
  logic [RW-1:0] ref_words[1000];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bit();
    bit b;
    b = hist[0] ^ hist[1] ^ hist[3] ^ hist[4];
    void'(hist.pop_front());
    hist.push_back(b);
    return b;
  endfunction

  function automatic logic [RW-1:0] model_word();
    logic [RW-1:0] w;
    w = '0;
    for (int i = 0; i < RW; i++) w[i] = model_bit();
    return w;
  endfunction

  // Prime the model with a seed and skip the discarded warm-up words.
  function automatic void model_seed(input logic [31:0] lo, input logic [31:0] hi);
    logic [63:0] s;
    s = {hi, lo};
    if (s == 64'd0) s = 64'd1;
    hist.delete();
    for (int j = 63; j >= 0; j--) hist.push_back(s[j]);
    for (int k = 0; k < WARM; k++) void'(model_word());
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_pair(input logic [31:0] lo, input logic [31:0] hi);
    seed_valid = 1'b1;
    seed_in    = lo;
    tick();
    seed_in    = hi;
    tick();
    seed_valid = 1'b0;
    seed_in    = 32'd0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!rnd_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(WARM + 1));
  endtask

  initial begin
    logic [31:0]   lo, hi;
    logic [RW-1:0] prev, w;
    int            idx, cyc, nz;
    bit            stalled;

    rst = 1'b1; seed_valid = 1'b0; seed_in = 32'd0; rnd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 64'({rnd_valid, seeded, rnd_out}), 64'd0);
    for (int i = 0; i < 300; i++) begin
      tick();
      check("idle_outputs", 64'({rnd_valid, seeded, rnd_out}), 64'd0);
    end

    // Fixed seed, consumer always ready.
    rnd_ready = 1'b1;
    seed_pair(32'hDEADBEEF, 32'h01234567);
    model_seed(32'hDEADBEEF, 32'h01234567);
    wait_valid("run1_latency");
    check("run1_seeded", 64'(seeded), 64'd1);
    for (int k = 0; k < 1000; k++) begin
      ref_words[k] = model_word();
      check("run1_word", 64'({rnd_valid, rnd_out}), 64'({1'b1, ref_words[k]}));
      tick();
    end

    // Same seed with random stalls: identical consumed sequence, held output while stalled.
    rnd_ready = 1'($urandom_range(0, 1));
    seed_pair(32'hDEADBEEF, 32'h01234567);
    idx = 0;
    cyc = 0;
    while (idx < 300 && cyc < 5000) begin
      rnd_ready = 1'($urandom_range(0, 1));
      if (rnd_valid && rnd_ready) begin
        check("stall_word", 64'(rnd_out), 64'(ref_words[idx]));
        idx++;
      end
      stalled = rnd_valid && !rnd_ready;
      prev    = rnd_out;
      tick();
      cyc++;
      if (stalled) check("stall_hold", 64'({rnd_valid, rnd_out}), 64'({1'b1, prev}));
    end
    check("stall_words_consumed", 64'(idx), 64'd300);

    // All-zero seed behaves as seed 1 and never locks up.
    rnd_ready = 1'b1;
    seed_pair(32'd0, 32'd0);
    model_seed(32'd1, 32'd0);
    wait_valid("zero_latency");
    nz = 0;
    for (int k = 0; k < 10000; k++) begin
      w = model_word();
      check("zero_word", 64'({rnd_valid, rnd_out}), 64'({1'b1, w}));
      if (rnd_out != '0) nz++;
      tick();
    end
    check("zero_nonzero_seen", 64'(nz > 1000), 64'd1);

    // Reseed in RUN while the consumer is ready: reseed wins.
    lo = $urandom();
    hi = $urandom();
    seed_valid = 1'b1;
    seed_in    = lo;
    tick();
    check("reseed_clear", 64'({rnd_valid, seeded}), 64'd0);
    seed_in = hi;
    tick();
    seed_valid = 1'b0;
    model_seed(lo, hi);
    wait_valid("reseed_latency");
    for (int k = 0; k < 50; k++) begin
      w = model_word();
      check("reseed_word", 64'({rnd_valid, rnd_out}), 64'({1'b1, w}));
      tick();
    end

    // Reset mid-warm-up dominates a concurrent seed word and ready.
    seed_pair($urandom(), $urandom());
    for (int i = 0; i < 30; i++) tick();
    check("warmup_not_valid", 64'(rnd_valid), 64'd0);
    rst = 1'b1; seed_valid = 1'b1; seed_in = $urandom(); rnd_ready = 1'b1;
    tick();
    rst = 1'b0; seed_valid = 1'b0;
    check("rst_warmup", 64'({rnd_valid, seeded, rnd_out}), 64'd0);
    lo = $urandom();
    hi = $urandom();
    seed_valid = 1'b1;
    seed_in    = lo;
    tick();
    seed_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      check("half_seed_wait", 64'({rnd_valid, seeded}), 64'd0);
      tick();
    end
    seed_valid = 1'b1;
    seed_in    = hi;
    tick();
    seed_valid = 1'b0;
    model_seed(lo, hi);
    wait_valid("post_rst_latency");
    for (int k = 0; k < 20; k++) begin
      w = model_word();
      check("post_rst_word", 64'({rnd_valid, rnd_out}), 64'({1'b1, w}));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
